// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the IF -> ID -> EX core: stall/flush/redirect control
// for PC, IF/ID and ID/EX, plus a saturating stall-cycle counter.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             ex_is_load_i,
  input  logic             ex_wen_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_busy_i,
  input  logic             jump_req_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             halt_req_i,
  input  logic             resume_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             pc_load_o,
  output logic [31:0]      pc_load_addr_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // The flush counter only has to hold FLUSH_CYCLES-1 extra cycles after the jump cycle.
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [FC_W-1:0] FC_ONE       = FC_W'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_BUSY  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [FC_W-1:0]  flush_cnt_reg, flush_cnt_next;
  logic [CNT_W-1:0] stall_cnt_reg;

  logic hazard;
  logic take_jump;
  logic hold;
  logic flush_if;

  assign hazard = id_valid_i & ex_is_load_i & ex_wen_i & (ex_rd_i != 5'd0) &
                  ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));

  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    take_jump      = 1'b0;
    hold           = 1'b0;
    flush_if       = 1'b0;

    case (state_reg)
      // BUSY decodes exactly like RUN: a still-busy op keeps it in BUSY,
      // and the release cycle is handled as an ordinary RUN cycle.
      ST_RUN, ST_BUSY: begin
        if (jump_req_i) begin
          take_jump = 1'b1;
        end else if (ex_busy_i) begin
          hold       = 1'b1;
          state_next = ST_BUSY;
        end else if (halt_req_i) begin
          state_next = ST_HALT;
        end else begin
          hold       = hazard;
          state_next = ST_RUN;
        end
      end
      ST_FLUSH: begin
        flush_if = 1'b1;
        if (jump_req_i) begin
          take_jump = 1'b1;
        end else if (flush_cnt_reg <= FC_ONE) begin
          flush_cnt_next = '0;
          state_next     = ST_RUN;
        end else begin
          flush_cnt_next = flush_cnt_reg - FC_ONE;
        end
      end
      ST_HALT: begin
        hold = 1'b1;
        if (resume_i) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase

    if (take_jump) begin
      flush_if       = 1'b1;
      flush_cnt_next = FLUSH_RELOAD;
      state_next     = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_RUN;
      flush_cnt_reg <= '0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
      if (hold && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  // Combinational outputs are gated so everything reads 0 while reset is held.
  assign pc_stall_o     = rst_n & hold;
  assign if_id_stall_o  = rst_n & hold;
  assign id_ex_flush_o  = rst_n & (hold | take_jump);
  assign if_id_flush_o  = rst_n & flush_if;
  assign pc_load_o      = rst_n & take_jump;
  assign pc_load_addr_o = (rst_n & take_jump) ? jump_addr_i : 32'd0;
  assign state_o        = state_reg;
  assign stall_cnt_o    = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the sequencing rules.
module tb_pipe_ctrl;

  localparam int FC   = 2;
  localparam int CW   = 5;
  localparam int MAXC = (1 << CW) - 1;
  localparam int VW   = 39 + CW;
  localparam int M_RUN = 0, M_FLUSH = 1, M_BUSY = 2, M_HALT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid_i, ex_is_load_i, ex_wen_i, ex_busy_i;
  logic [4:0]    id_rs1_i, id_rs2_i, ex_rd_i;
  logic          jump_req_i, halt_req_i, resume_i;
  logic [31:0]   jump_addr_i;
  logic          pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_flush_o, pc_load_o;
  logic [31:0]   pc_load_addr_o;
  logic [1:0]    state_o;
  logic [CW-1:0] stall_cnt_o;

  int checks = 0;
  int failures = 0;

  // behavioural model state
  int m_mode, m_left, m_stalls;
  int n_mode, n_left;
  logic e_stall, e_ifflush, e_idexflush, e_load;
  logic [31:0] e_addr;

  pipe_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .ex_is_load_i(ex_is_load_i), .ex_wen_i(ex_wen_i), .ex_rd_i(ex_rd_i),
    .ex_busy_i(ex_busy_i), .jump_req_i(jump_req_i), .jump_addr_i(jump_addr_i),
    .halt_req_i(halt_req_i), .resume_i(resume_i),
    .pc_stall_o(pc_stall_o), .if_id_stall_o(if_id_stall_o),
    .if_id_flush_o(if_id_flush_o), .id_ex_flush_o(id_ex_flush_o),
    .pc_load_o(pc_load_o), .pc_load_addr_o(pc_load_addr_o),
    .state_o(state_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] dut_vec();
    return {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_flush_o, pc_load_o,
            pc_load_addr_o, state_o, stall_cnt_o};
  endfunction

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [1:0]    st;
    logic [CW-1:0] sc;
    st = 2'(m_mode);
    sc = CW'(sat(m_stalls));
    return {e_stall, e_stall, e_ifflush, e_idexflush, e_load, e_addr, st, sc};
  endfunction

  task automatic set_idle();
    id_valid_i = 0; ex_is_load_i = 0; ex_wen_i = 0; ex_busy_i = 0;
    id_rs1_i = 0; id_rs2_i = 0; ex_rd_i = 0;
    jump_req_i = 0; jump_addr_i = 0; halt_req_i = 0; resume_i = 0;
  endtask

  task automatic model_reset();
    m_mode = M_RUN; m_left = 0; m_stalls = 0;
  endtask

  // Expected outputs for the current cycle and the mode after the next edge.
  task automatic model_eval();
    bit hz;
    hz = id_valid_i && ex_is_load_i && ex_wen_i && (ex_rd_i != 0) &&
         (ex_rd_i == id_rs1_i || ex_rd_i == id_rs2_i);
    e_stall = 0; e_ifflush = 0; e_idexflush = 0; e_load = 0; e_addr = 0;
    n_mode = m_mode; n_left = m_left;
    if (m_mode != M_HALT && jump_req_i) begin
      e_load = 1; e_addr = jump_addr_i; e_ifflush = 1; e_idexflush = 1;
      n_left = FC - 1;
      n_mode = (n_left > 0) ? M_FLUSH : M_RUN;
    end else if (m_mode == M_FLUSH) begin
      e_ifflush = 1;
      n_left = m_left - 1;
      n_mode = (n_left == 0) ? M_RUN : M_FLUSH;
    end else if (m_mode == M_HALT) begin
      e_stall = 1; e_idexflush = 1;
      n_mode = resume_i ? M_RUN : M_HALT;
    end else if (ex_busy_i) begin
      e_stall = 1; e_idexflush = 1; n_mode = M_BUSY;
    end else if (halt_req_i) begin
      n_mode = M_HALT;
    end else begin
      e_stall = hz; e_idexflush = hz; n_mode = M_RUN;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_mode = n_mode; m_left = n_left;
    if (e_stall) m_stalls++;
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1;
    #1 rst_n = 0;
    #2 ex_busy_i = 1; jump_req_i = 1; jump_addr_i = $urandom;
    #1;
    checks++;
    if (dut_vec() !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", dut_vec());
    end
    set_idle();
    model_reset();
    @(posedge clk); #2 rst_n = 1;
    model_eval();
    @(negedge clk);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL reset_release got=%h exp=%h", dut_vec(), exp_vec());
    end
    tick();
  endtask

  task automatic test_hazard();
    for (int c = 0; c < 3; c++) begin
      set_idle();
      if (c < 2) begin
        id_valid_i = 1; ex_is_load_i = 1; ex_wen_i = 1; ex_rd_i = 5;
        id_rs1_i = (c == 0) ? 5'd5 : 5'd9;
        id_rs2_i = (c == 0) ? 5'd7 : 5'd5;
      end
      model_eval();
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL hazard cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      checks++;
      if (pc_stall_o !== (c < 2) || state_o !== 2'd0) begin
        failures++; $display("FAIL hazard_stall cyc=%0d got=%b/%0d exp=%b/0", c, pc_stall_o, state_o, c < 2);
      end
      tick();
    end
  endtask

  task automatic test_x0();
    set_idle();
    id_valid_i = 1; ex_is_load_i = 1; ex_wen_i = 1; ex_rd_i = 0; id_rs1_i = 0; id_rs2_i = 0;
    model_eval();
    @(negedge clk);
    checks++;
    if (dut_vec() !== exp_vec() || pc_stall_o !== 1'b0) begin
      failures++; $display("FAIL x0_nostall got=%h exp=%h", dut_vec(), exp_vec());
    end
    tick();
  endtask

  task automatic test_jump(input bit with_hazard);
    for (int c = 0; c < 3; c++) begin
      set_idle();
      if (c == 0) begin
        jump_req_i = 1; jump_addr_i = 32'h0000_0100;
        if (with_hazard) begin
          id_valid_i = 1; ex_is_load_i = 1; ex_wen_i = 1; ex_rd_i = 3; id_rs1_i = 3;
        end
      end
      model_eval();
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL jump h=%0d cyc=%0d got=%h exp=%h", with_hazard, c, dut_vec(), exp_vec());
      end
      checks++;
      if (pc_load_o !== (c == 0) || if_id_flush_o !== (c < 2) || pc_stall_o !== 1'b0 ||
          (c == 0 && pc_load_addr_o !== 32'h100) || state_o !== ((c == 1) ? 2'd1 : 2'd0)) begin
        failures++;
        $display("FAIL jump_seq h=%0d cyc=%0d got load=%b addr=%h flush=%b stall=%b st=%0d",
                 with_hazard, c, pc_load_o, pc_load_addr_o, if_id_flush_o, pc_stall_o, state_o);
      end
      tick();
    end
  endtask

  task automatic test_busy();
    int base;
    base = m_stalls;
    for (int c = 0; c < 6; c++) begin
      set_idle();
      ex_busy_i = (c < 5);
      model_eval();
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL busy cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      if (c == 5) begin
        checks++;
        if (state_o !== 2'd2 || pc_stall_o !== 1'b0 || stall_cnt_o !== CW'(sat(base + 5))) begin
          failures++; $display("FAIL busy_end got st=%0d stall=%b cnt=%0d exp st=2 stall=0 cnt=%0d",
                               state_o, pc_stall_o, stall_cnt_o, sat(base + 5));
        end
      end
      tick();
    end
    // redirect arriving as the multi-cycle op finishes
    for (int c = 0; c < 5; c++) begin
      set_idle();
      ex_busy_i = (c < 2);
      if (c == 2) begin jump_req_i = 1; jump_addr_i = $urandom; end
      model_eval();
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec() || (c == 2 && pc_load_o !== 1'b1)) begin
        failures++; $display("FAIL busy_jump cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_halt();
    for (int c = 0; c < 5; c++) begin
      set_idle();
      halt_req_i = (c < 4);
      resume_i   = (c == 3);
      if (c == 1) begin jump_req_i = 1; jump_addr_i = $urandom; end
      model_eval();
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL halt cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      checks++;
      if (state_o !== ((c >= 1 && c <= 3) ? 2'd3 : 2'd0) || pc_load_o !== 1'b0) begin
        failures++; $display("FAIL halt_state cyc=%0d got st=%0d load=%b", c, state_o, pc_load_o);
      end
      tick();
    end
  endtask

  task automatic test_saturate();
    for (int c = 0; c < 41; c++) begin
      set_idle();
      ex_busy_i = (c < 40);
      model_eval();
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL saturate cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      tick();
    end
    checks++;
    if (stall_cnt_o !== CW'(MAXC)) begin
      failures++; $display("FAIL saturate_hold got=%0d exp=%0d", stall_cnt_o, MAXC);
    end
  endtask

  task automatic test_async_reset();
    set_idle();
    ex_busy_i = 1;
    for (int c = 0; c < 3; c++) begin
      model_eval();
      tick();
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (dut_vec() !== '0) begin
      failures++; $display("FAIL async_reset got=%h exp=0", dut_vec());
    end
    model_reset();
    set_idle();
    @(posedge clk); #2 rst_n = 1;
    for (int c = 0; c < 2; c++) begin
      model_eval();
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec() || state_o !== 2'd0) begin
        failures++; $display("FAIL async_release cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      id_valid_i   = ($urandom_range(0, 3) != 0);
      ex_is_load_i = $urandom_range(0, 1);
      ex_wen_i     = ($urandom_range(0, 3) != 0);
      ex_rd_i      = 5'($urandom_range(0, 3));
      id_rs1_i     = 5'($urandom_range(0, 3));
      id_rs2_i     = 5'($urandom_range(0, 3));
      ex_busy_i    = ($urandom_range(0, 6) == 0);
      jump_req_i   = ($urandom_range(0, 9) == 0);
      jump_addr_i  = $urandom;
      halt_req_i   = ($urandom_range(0, 15) == 0);
      resume_i     = ($urandom_range(0, 3) == 0);
      model_eval();
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL random cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      tick();
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_hazard();
    test_x0();
    test_jump(1'b0);
    test_jump(1'b1);
    test_busy();
    test_halt();
    test_saturate();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
